// File: rtl/vga_stream_sink.sv
// Avalon-ST video sink: buffers {sop,eop,pixel} beats in a small FIFO and
// replays them against free-running VGA timing, re-locking on framing errors.
module vga_stream_sink #(
  parameter int DATA_W     = 30,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              startofpacket,
  input  logic              endofpacket,
  input  logic              valid,
  output logic              ready,
  output logic [DATA_W-1:0] vga_rgb,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic              underflow,
  output logic              sync_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_AL   = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_AL   = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [PW-1:0] FULL_CNT = PW'(FIFO_DEPTH);

  typedef enum logic [1:0] {SEEK_SOP, WAIT_VSTART, STREAM} state_e;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] pix;
  } word_t;

  state_e            state_q, state_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [VW-1:0]     vcnt_q, vcnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_d;
  logic              flush_q, flush_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rgb_q, rgb_d;
  logic              hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic              underflow_q, underflow_d, sync_err_q, sync_err_d;
  word_t             mem_q [FIFO_DEPTH];
  word_t             rd_word, wr_word;
  logic              push, pop, empty, active, at_origin, at_last, stream_px;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign rd_word   = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_word   = '{sop: startofpacket, eop: endofpacket, pix: data};
  assign active    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign at_origin = (hcnt_q == '0) && (vcnt_q == '0);
  assign at_last   = (hcnt_q == H_AL) && (vcnt_q == V_AL);
  // WAIT_VSTART behaves as STREAM on the (0,0) pixel so the sop word pops there.
  assign stream_px = active &&
                     ((state_q == STREAM) || ((state_q == WAIT_VSTART) && at_origin));

  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    push        = 1'b0;
    pop         = 1'b0;
    flush_d     = 1'b0;
    rgb_d       = '0;
    sync_err_d  = 1'b0;
    underflow_d = underflow_q;
    hs_d        = ~((hcnt_q >= H_SS) && (hcnt_q < H_SE));
    vs_d        = ~((vcnt_q >= V_SS) && (vcnt_q < V_SE));
    blank_n_d   = active;

    if (stream_px) begin
      if (empty) begin
        underflow_d = 1'b1;
        sync_err_d  = 1'b1;
        flush_d     = 1'b1;
        state_d     = SEEK_SOP;
      end else begin
        pop = 1'b1;
        if ((rd_word.sop != at_origin) || (rd_word.eop != at_last)) begin
          sync_err_d = 1'b1;
          flush_d    = 1'b1;
          state_d    = SEEK_SOP;
        end else begin
          rgb_d   = rd_word.pix;
          state_d = STREAM;
        end
      end
    end

    // Beats accepted while a flush is pending belong to the aborted frame.
    if (valid && ready_q && !flush_q) begin
      if (state_q == SEEK_SOP) begin
        if (startofpacket) begin
          push    = 1'b1;
          state_d = WAIT_VSTART;
        end
      end else begin
        push = 1'b1;
      end
    end

    wr_ptr_d = flush_q ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = flush_q ? '0 : rd_ptr_q + PW'(pop);
    count_d  = wr_ptr_d - rd_ptr_d;
    // Registered from next-state so a pop never frees space in its own cycle.
    ready_d  = (state_d == SEEK_SOP) || (count_d != FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEEK_SOP;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      flush_q     <= 1'b0;
      ready_q     <= 1'b0;
      rgb_q       <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_n_q   <= 1'b0;
      underflow_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      flush_q     <= flush_d;
      ready_q     <= ready_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      blank_n_q   <= blank_n_d;
      underflow_q <= underflow_d;
      sync_err_q  <= sync_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
  end

  assign ready       = ready_q;
  assign vga_rgb     = rgb_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign underflow   = underflow_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_stream_sink.sv
// Reduced-geometry bench: a ramp source with stalls and injected framing
// faults, checked against a frame-position / beat-queue reference model.
module tb_vga_stream_sink;
  localparam int DW = 30;
  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int NPIX = HA * VA;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data = '0;
  logic          sop = 1'b0, eop = 1'b0, valid = 1'b0;
  logic          ready, vga_hs, vga_vs, vga_blank_n, underflow, sync_err;
  logic [DW-1:0] vga_rgb;

  always #5 clk = ~clk;

  vga_stream_sink #(
    .DATA_W(DW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .startofpacket(sop),
    .endofpacket(eop), .valid(valid), .ready(ready), .vga_rgb(vga_rgb),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .underflow(underflow), .sync_err(sync_err)
  );

  typedef struct {
    logic          s;
    logic          e;
    logic [DW-1:0] d;
  } beat_t;

  int total = 0, bad = 0;

  // Reference: beats queued in the sink, lock mode (0 seek, 1 wait, 2 show)
  beat_t q[$];
  int    st = 0, mt = 0;
  bit    flush_p = 0, uf = 0;
  logic [DW-1:0] e_rgb = '0;
  logic  e_hs = 1, e_vs = 1, e_bl = 0, e_serr = 0, e_ready = 0;

  // Ramp source
  bit src_on = 0;
  int src_p = 0, src_frame = 0, inj_p = -1, vprob = 100;
  int serr_cnt = 0, hs_lo = 0, vs_lo = 0, bl_hi = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=event at %0t", tag, $time);
  endtask

  task automatic cycle(input bit rst);
    bit    acc, act, org, lst, fl;
    int    h, v, st0;
    beat_t w, nb;
    reset = rst;
    valid = src_on && ($urandom_range(99) < vprob);
    sop   = (src_p == 0);
    eop   = (src_p == NPIX - 1) || (src_p == inj_p);
    data  = DW'(src_frame * 1024 + src_p);
    #1;
    if (!rst) chk("ready", {31'd0, ready}, {31'd0, e_ready});
    acc = valid && ready && !rst;
    nb  = '{s: sop, e: eop, d: data};
    if (acc) begin
      if (src_p == inj_p) inj_p = -1;
      src_p++;
      if (src_p == NPIX) begin src_p = 0; src_frame++; end
    end
    if (rst) begin
      q.delete(); st = 0; mt = 0; flush_p = 0; uf = 0;
      e_rgb = '0; e_hs = 1; e_vs = 1; e_bl = 0; e_serr = 0; e_ready = 0;
    end else begin
      h = mt % HT; v = (mt / HT) % VT; mt++;
      act = (h < HA) && (v < VA);
      org = (h == 0) && (v == 0);
      lst = (h == HA - 1) && (v == VA - 1);
      e_bl = act;
      e_hs = !(h >= HA + HFP && h < HA + HFP + HS);
      e_vs = !(v >= VA + VFP && v < VA + VFP + VS);
      e_rgb = '0; e_serr = 0; fl = 0; st0 = st;
      if (act && (st == 2 || (st == 1 && org))) begin
        if (q.size() == 0) begin
          uf = 1; e_serr = 1; fl = 1; st = 0;
        end else begin
          w = q.pop_front();
          if (w.s != org || w.e != lst) begin
            e_serr = 1; fl = 1; st = 0;
          end else begin
            e_rgb = w.d; st = 2;
          end
        end
      end
      if (flush_p) q.delete();
      else if (acc) begin
        if (st0 == 0) begin
          if (nb.s) begin q.push_back(nb); st = 1; end
        end else q.push_back(nb);
      end
      flush_p = fl;
      e_ready = (st == 0) || (q.size() < DEPTH);
    end
    @(posedge clk);
    #1;
    chk("rgb", {2'b0, vga_rgb}, {2'b0, e_rgb});
    chk("hs", {31'd0, vga_hs}, {31'd0, e_hs});
    chk("vs", {31'd0, vga_vs}, {31'd0, e_vs});
    chk("blank_n", {31'd0, vga_blank_n}, {31'd0, e_bl});
    chk("underflow", {31'd0, underflow}, {31'd0, uf});
    chk("sync_err", {31'd0, sync_err}, {31'd0, e_serr});
    if (sync_err === 1'b1) serr_cnt++;
    if (vga_hs === 1'b0) hs_lo++;
    if (vga_vs === 1'b0) vs_lo++;
    if (vga_blank_n === 1'b1) bl_hi++;
  endtask

  task automatic wait_pos(input int wh, input int wv, input string tag);
    int n = 0;
    while (!((mt % HT) == wh && ((mt / HT) % VT) == wv) && n < 2 * FT) begin
      cycle(0); n++;
    end
    if (n >= 2 * FT) timeout(tag);
  endtask

  initial begin
    int base, n;
    // Reset and continuous ramp from pixel 0
    repeat (3) cycle(1);
    src_on = 1;
    base = serr_cnt;
    repeat (FT + 10) cycle(0);
    hs_lo = 0; vs_lo = 0; bl_hi = 0;
    repeat (FT) cycle(0);
    chk("hs_low_clocks", hs_lo, VT * HS);
    chk("vs_low_clocks", vs_lo, VS * HT);
    chk("blank_n_high_clocks", bl_hi, HA * VA);
    repeat (FT) cycle(0);
    chk("clean_sync_err", serr_cnt - base, 0);
    chk("clean_underflow", {31'd0, underflow}, 32'd0);

    // Source starts mid-frame without sop
    src_on = 0;
    repeat (2) cycle(1);
    src_p = 40; src_frame = 5; src_on = 1;
    base = serr_cnt;
    repeat (3 * FT) cycle(0);
    chk("midstart_sync_err", serr_cnt - base, 0);
    chk("midstart_underflow", {31'd0, underflow}, 32'd0);

    // Source stalls for 40 cycles during line 3
    wait_pos(0, 3, "wait_line3");
    base = serr_cnt;
    src_on = 0;
    repeat (40) cycle(0);
    src_on = 1;
    chk("underflow_set", {31'd0, underflow}, 32'd1);
    repeat (3 * FT) cycle(0);
    chk("underflow_sticky", {31'd0, underflow}, 32'd1);
    chk("underflow_one_err", serr_cnt - base, 1);

    // Early eop at pixel 50 of a frame that is being displayed
    n = 0;
    while (!(st == 2 && src_p > 0 && src_p < 30) && n < 2 * FT) begin cycle(0); n++; end
    if (n >= 2 * FT) timeout("wait_stream");
    base = serr_cnt;
    inj_p = 50;
    repeat (3 * FT) cycle(0);
    chk("early_eop_one_err", serr_cnt - base, 1);

    // Random stalls and random early eops
    vprob = 92;
    for (int f = 0; f < 4; f++) begin
      if ($urandom_range(1) == 1) inj_p = $urandom_range(NPIX - 2, 1);
      repeat (FT) cycle(0);
    end
    vprob = 100; inj_p = -1;
    repeat (2 * FT) cycle(0);

    // Full-rate display with a full FIFO, then reset in the middle of line 3
    wait_pos(HA / 2, 3, "wait_midline");
    cycle(1);
    repeat (FT + 20) cycle(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_stream_sink.md
Name: vga_stream_sink

Overview:
- Avalon-ST video sink: consumes the 640x480, 30-bit RGB packet stream (startofpacket/endofpacket framing) from the video sources, e.g. the face generator.
- Buffers beats in a small FIFO and drives 640x480@60 VGA timing (hsync, vsync, blank_n, 30-bit RGB) from a single pixel clock.
- Locks to the stream on startofpacket and detects framing errors and underflow, re-locking automatically.

Parameters:
- DATA_W, 30, pixel width: 10 bits each R, G, B, with R in the MSBs.
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in clocks.
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines.
- FIFO_DEPTH, 16, pixel FIFO entries; power of 2, minimum 4.

Ports:
- clk  in  1  pixel clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- data  in  DATA_W  Avalon-ST pixel.
- startofpacket  in  1  first pixel of a frame.
- endofpacket  in  1  last pixel of a frame.
- valid  in  1  source has a beat.
- ready  out  1  sink accepts a beat.
- vga_rgb  out  DATA_W  pixel to the DAC; 0 while blanked.
- vga_hs  out  1  horizontal sync, active-low.
- vga_vs  out  1  vertical sync, active-low.
- vga_blank_n  out  1  high during active video.
- underflow  out  1  sticky; set on an FIFO-empty pop during active video; cleared only by reset.
- sync_err  out  1  one-cycle pulse when a framing error forces re-lock.

Behaviour:
- Reset values: ready=0, vga_rgb=0, vga_hs=1, vga_vs=1, vga_blank_n=0, underflow=0, sync_err=0, hcnt=vcnt=0, FIFO empty, state=SEEK_SOP. Reset mid-frame aborts everything the same way.
- Timing:
  - hcnt runs 0..H_TOTAL-1 (800), then wraps to 0 and increments vcnt.
  - vcnt runs 0..V_TOTAL-1 (525), then wraps to 0.
  - Active region: hcnt<640 and vcnt<480.
  - hs low for hcnt in [656,751]; vs low for vcnt in [490,491].
  - Counters free-run in every state.
- Output latency: vga_rgb, vga_hs, vga_vs and vga_blank_n are registered. Values for counter position (h,v) appear one cycle later, and all four outputs stay mutually aligned.
- Handshake:
  - A beat is accepted when valid & ready.
  - ready=1 in SEEK_SOP; otherwise ready = ~fifo_full.
  - ready does not depend on valid.
  - A same-cycle pop does not free space for a push in that cycle.
- FIFO word: {sop, eop, data}.
- State SEEK_SOP:
  - Accepted beats with sop=0 are discarded.
  - An accepted beat with sop=1 is written to the FIFO; go to WAIT_VSTART.
- State WAIT_VSTART:
  - Accept beats into the FIFO; no pops; outputs blank.
  - When the counters reach (0,0), go to STREAM; that cycle's (0,0) pixel pops the sop word.
- State STREAM: on each active-region cycle, pop one word and output its data.
- Framing errors (popped word):
  - sop=1 at a position other than (0,0).
  - eop=1 at a position other than (639,479).
  - eop=0 at (639,479).
  - On any error: pulse sync_err, flush the FIFO next cycle (a beat accepted in the flush cycle is dropped), output black for the offending pixel, go to SEEK_SOP.
- Underflow: an active-region pixel in STREAM with the FIFO empty outputs rgb=0, sets underflow, pulses sync_err and goes to SEEK_SOP. A frame is never resumed mid-way.
- Blanking: vga_rgb=0 whenever blank_n=0, in every state. Outside STREAM, active pixels are black.
- Wrap-around: after a good eop at (639,479), stay in STREAM. The next frame's sop must pop at the next (0,0).

Test Plan:
- Reset, then continuous valid source with a 640x480 ramp (data = pixel index) → first active pixel at (0,0) shows data=0 one cycle after hcnt=vcnt=0. Pixel (639,479) shows 307199. 60 consecutive frames give underflow=0 and sync_err never set.
- Timing check → hs low for exactly 96 clocks per 800-clock line; vs low for exactly 2 lines (1600 clocks) per 525-line frame; blank_n high for 640 clocks on each of 480 lines.
- Start the source mid-frame, at pixel 1000 with sop=0 → beats discarded until the next sop; lock at the following (0,0); no sync_err.
- Deassert valid for 40 cycles during line 100 → FIFO empties, underflow=1 sticky, sync_err pulse, black pixels; re-lock on the next sop with correct image.
- Inject an early eop at pixel 5000 → sync_err pulse at that pixel's pop, FIFO flushed, next frame displays correctly.
- Hold valid high with vga output at full rate, FIFO full → ready=0 until a pop; no beat is lost or duplicated (scoreboard compare); assert reset mid-line 200 → all outputs return to reset values on the next cycle.
